fifo_width_conv: RTL and testbench
==================================

# fifo_width_conv

Single-clock synchronous FIFO with write-to-read width down-conversion. It is the parametrised successor of the fixed 8-bit-in / 2-bit-out FIFO path. Writers push WR_WIDTH-bit words and readers pop WR_WIDTH/RATIO-bit slices, most-significant slice first. It sits between a wide producer and a narrow consumer in the same clock domain. It adds programmable almost-full/almost-empty thresholds, occupancy counts on both sides, and sticky-free overflow/underflow error pulses.

## Interface
Parameters:
- WR_WIDTH, 8, write word width in bits.
- RATIO, 4, slices per write word; must be 1, 2, 4 or 8 and divide WR_WIDTH. RD_WIDTH = WR_WIDTH/RATIO.
- DEPTH, 16, storage depth in write words; power of 2, ≥ 4.
- AF_TH, DEPTH-2, almost_full asserts when wr_count ≥ AF_TH.
- AE_TH, 2, almost_empty asserts when rd_count ≤ AE_TH.

Ports:
- sys_clk  in  1  sole clock, rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write request.
- wr_data  in  WR_WIDTH  write word.
- full  out  1  wr_count == DEPTH.
- almost_full  out  1  wr_count ≥ AF_TH.
- overflow  out  1  one-cycle pulse: wr_en while full.
- rd_en  in  1  read request for one slice.
- rd_data  out  RD_WIDTH  registered read slice.
- empty  out  1  rd_count == 0.
- almost_empty  out  1  rd_count ≤ AE_TH.
- underflow  out  1  one-cycle pulse: rd_en while empty.
- wr_count  out  clog2(DEPTH)+1  words held, including a partially read word.
- rd_count  out  clog2(DEPTH*RATIO)+1  slices available = wr_count*RATIO − slice_idx.

## Operation
- Storage: DEPTH × WR_WIDTH array, write pointer wp and read pointer rp, each clog2(DEPTH) bits, wrapping modulo DEPTH. Registered slice index slice_idx ∈ [0, RATIO−1].
- Write accepted iff wr_en && !full. mem[wp] ← wr_data, wp+1, wr_count+1.
- Read accepted iff rd_en && !empty. rd_data ← mem[rp][WR_WIDTH−1−slice_idx*RD_WIDTH -: RD_WIDTH]. This makes the MSB slice first.
- After an accepted read, if slice_idx == RATIO−1, then slice_idx ← 0, rp+1 and wr_count−1. Otherwise slice_idx+1.
- Simultaneous accepted write and a word-freeing read: wr_count unchanged and rd_count +RATIO−1. Accepted write with a non-freeing read: wr_count+1 and rd_count +RATIO−1.
- full is evaluated on the registered count before the edge. A write while full is refused even if the same cycle's read frees a word. The write raises overflow and the memory is not modified.
- A read while empty is refused, raises underflow, and leaves rd_data holding its last value. A write in the same cycle is still accepted.
- RATIO == 1 degenerates to a plain FIFO. slice_idx is held at 0.
- Flags and counts are combinational functions of registered wp/rp/wr_count/slice_idx only. There is no path from wr_en or rd_en to any flag.

## Timing
- Reset: when sys_rst_n is low at a rising edge, wp, rp, slice_idx and wr_count are set to 0 and rd_data to 0. overflow and underflow go to 0.
- Reset resulting state: empty=1, almost_empty=1, full=0, almost_full=0 (for AF_TH > 0), rd_count=0.
- Reset mid-operation discards all contents. An access requested in the reset cycle is ignored.
- Write-to-read latency: a word written at edge N makes empty low after edge N. The first slice can be requested in cycle N+1 and appears on rd_data after edge N+2.
- Read latency: 1 cycle. rd_data is valid from the edge that accepts rd_en and holds until the next accepted read.
- Full throughput: one write per cycle and one slice read per cycle, sustained. With RATIO > 1 the FIFO fills at a net (RATIO−1)/RATIO words/cycle under full-rate writes.
- overflow and underflow are asserted for exactly the cycle following the offending request, one pulse per refused request.
- Memory is inferred as distributed or block RAM with a registered output. No read-during-write hazard exists because rp ≠ wp whenever !empty && a write is accepted.

## Test plan
- Default params: write 0xB4, then issue 4 reads. rd_data must be 2, 3, 1, 0. empty must rise after the 4th read and wr_count must go 1→0 on that edge.
- Write 16 words 0x00..0x0F with no reads. full=1 and almost_full from wr_count=14. A 17th write of 0xFF gives overflow for 1 cycle and the subsequent 64 reads return the original data with no 0xFF slices.
- After reset, rd_en for 3 cycles. underflow pulses 3 times, rd_data stays 0, and counts stay 0.
- With continuous wr_en and rd_en at RATIO=4, compare against a scoreboard for 200 cycles. No data loss until full, and rd_count always equals wr_count*4 − slice_idx.
- Write 5 words, read 6 slices, then deassert sys_rst_n for 1 cycle. All counts and flags return to their reset values, and a following write of 0x5A reads back as 1, 1, 2, 2.
- WR_WIDTH=16, RATIO=2, DEPTH=8: write 0xA1B2 then 0xC3D4. Reads return 0xA1, 0xB2, 0xC3, 0xD4. almost_empty tracks rd_count ≤ 2.

Source files
------------

// File: rtl/fifo_width_conv_if.sv
// Bus bundle for fifo_width_conv: wide write side, narrow read side, status flags and counts.
interface fifo_width_conv_if #(
  parameter int WR_WIDTH = 8,
  parameter int RATIO    = 4,
  parameter int DEPTH    = 16
);
  localparam int RD_WIDTH = WR_WIDTH / RATIO;
  localparam int WCW      = $clog2(DEPTH) + 1;
  localparam int RCW      = $clog2(DEPTH * RATIO) + 1;

  logic                wr_en;
  logic [WR_WIDTH-1:0] wr_data;
  logic                full;
  logic                almost_full;
  logic                overflow;
  logic                rd_en;
  logic [RD_WIDTH-1:0] rd_data;
  logic                empty;
  logic                almost_empty;
  logic                underflow;
  logic [WCW-1:0]      wr_count;
  logic [RCW-1:0]      rd_count;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, overflow, rd_data, empty, almost_empty,
           underflow, wr_count, rd_count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, overflow, rd_data, empty, almost_empty,
           underflow, wr_count, rd_count
  );
endinterface

// File: rtl/fifo_width_conv.sv
// Single-clock FIFO taking WR_WIDTH-bit words and returning WR_WIDTH/RATIO-bit slices, MSB slice first.
module fifo_width_conv #(
  parameter int WR_WIDTH = 8,
  parameter int RATIO    = 4,
  parameter int DEPTH    = 16,
  parameter int AF_TH    = DEPTH - 2,
  parameter int AE_TH    = 2
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  fifo_width_conv_if.slave bus
);
  localparam int RD_WIDTH = WR_WIDTH / RATIO;
  localparam int AW       = $clog2(DEPTH);
  localparam int SW       = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int RSH      = $clog2(RATIO);
  localparam int WCW      = AW + 1;
  localparam int RCW      = $clog2(DEPTH * RATIO) + 1;

  logic [WR_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wp;
  logic [AW-1:0]       r_rp;
  logic [SW-1:0]       r_slice;
  logic [WCW-1:0]      r_wr_count;
  logic [RD_WIDTH-1:0] r_rd_data;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_full;
  logic                w_empty;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_last;
  logic [RCW-1:0]      w_rd_count;
  logic [WR_WIDTH-1:0] w_word;
  logic [RD_WIDTH-1:0] w_slice_data;

  assign w_rd_count = (RCW'(r_wr_count) << RSH) - RCW'(r_slice);
  assign w_full     = (r_wr_count == WCW'(DEPTH));
  assign w_empty    = (w_rd_count == '0);
  assign w_wr_acc   = bus.wr_en && !w_full;
  assign w_rd_acc   = bus.rd_en && !w_empty;
  // With RATIO == 1 the index is pinned at 0, so every read frees a word.
  assign w_last     = (r_slice == SW'(RATIO - 1));
  assign w_word     = r_mem[r_rp];

  always_comb begin
    w_slice_data = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (r_slice == SW'(i)) begin
        w_slice_data = w_word[WR_WIDTH-1-i*RD_WIDTH -: RD_WIDTH];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n && w_wr_acc) begin
      r_mem[r_wp] <= bus.wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_slice     <= '0;
      r_wr_count  <= '0;
      r_rd_data   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= bus.wr_en && w_full;
      r_underflow <= bus.rd_en && w_empty;
      if (w_wr_acc) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_data <= w_slice_data;
        if (w_last) begin
          r_slice <= '0;
          r_rp    <= r_rp + AW'(1);
        end else begin
          r_slice <= r_slice + SW'(1);
        end
      end
      if (w_wr_acc && !(w_rd_acc && w_last)) begin
        r_wr_count <= r_wr_count + WCW'(1);
      end else if (!w_wr_acc && w_rd_acc && w_last) begin
        r_wr_count <= r_wr_count - WCW'(1);
      end
    end
  end

  assign bus.full         = w_full;
  assign bus.almost_full  = (r_wr_count >= WCW'(AF_TH));
  assign bus.overflow     = r_overflow;
  assign bus.rd_data      = r_rd_data;
  assign bus.empty        = w_empty;
  assign bus.almost_empty = (w_rd_count <= RCW'(AE_TH));
  assign bus.underflow    = r_underflow;
  assign bus.wr_count     = r_wr_count;
  assign bus.rd_count     = w_rd_count;
endmodule

// File: tb/tb_fifo_width_conv.sv
// Scoreboard bench for fifo_width_conv: 8/4/16 default instance plus a 16/2/8 instance.
module tb_fifo_width_conv;
  logic clk;
  logic rst_n;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_width_conv_if #(.WR_WIDTH(8),  .RATIO(4), .DEPTH(16)) b1();
  fifo_width_conv_if #(.WR_WIDTH(16), .RATIO(2), .DEPTH(8))  b2();

  fifo_width_conv #(.WR_WIDTH(8), .RATIO(4), .DEPTH(16), .AF_TH(14), .AE_TH(2)) u_dut1 (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (b1.slave)
  );

  fifo_width_conv #(.WR_WIDTH(16), .RATIO(2), .DEPTH(8), .AF_TH(6), .AE_TH(2)) u_dut2 (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] q1[$];
  logic [7:0] q2[$];

  int m_words = 0;
  int m_slice = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: pop one expected slice per read accepted at this edge.
  always @(posedge clk) begin : mon1
    logic acc;
    logic [1:0] e;
    acc = b1.rd_en && !b1.empty && rst_n;
    if (acc) begin
      #1;
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon1_unexpected_read: got %0h expected none", b1.rd_data);
      end else begin
        e = q1.pop_front();
        chk("mon1_rd_data", 32'(b1.rd_data), 32'(e));
      end
    end
  end

  always @(posedge clk) begin : mon2
    logic acc;
    logic [7:0] e;
    acc = b2.rd_en && !b2.empty && rst_n;
    if (acc) begin
      #1;
      if (q2.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon2_unexpected_read: got %0h expected none", b2.rd_data);
      end else begin
        e = q2.pop_front();
        chk("mon2_rd_data", 32'(b2.rd_data), 32'(e));
      end
    end
  end

  task automatic push_word(input logic [7:0] wd);
    q1.push_back(wd[7:6]);
    q1.push_back(wd[5:4]);
    q1.push_back(wd[3:2]);
    q1.push_back(wd[1:0]);
  endtask

  // One cycle on the default instance, checked against a word/slice occupancy model.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re, output logic wa);
    int rd;
    logic ra, eov, eun;
    rd  = m_words * 4 - m_slice;
    b1.wr_en   = we;
    b1.wr_data = wd;
    b1.rd_en   = re;
    wa  = we && (m_words != 16);
    ra  = re && (rd != 0);
    eov = we && (m_words == 16);
    eun = re && (rd == 0);
    if (ra) begin
      if (m_slice == 3) begin
        m_slice = 0;
        m_words--;
      end else begin
        m_slice++;
      end
    end
    if (wa) m_words++;
    @(negedge clk);
    b1.wr_en = 1'b0;
    b1.rd_en = 1'b0;
    rd = m_words * 4 - m_slice;
    chk("overflow",     32'(b1.overflow),     32'(eov));
    chk("underflow",    32'(b1.underflow),    32'(eun));
    chk("wr_count",     32'(b1.wr_count),     32'(m_words));
    chk("rd_count",     32'(b1.rd_count),     32'(rd));
    chk("empty",        32'(b1.empty),        32'(rd == 0));
    chk("full",         32'(b1.full),         32'(m_words == 16));
    chk("almost_full",  32'(b1.almost_full),  32'(m_words >= 14));
    chk("almost_empty", 32'(b1.almost_empty), 32'(rd <= 2));
  endtask

  task automatic do_reset(input logic we, input logic re);
    b1.wr_en   = we;
    b1.wr_data = 8'hEE;
    b1.rd_en   = re;
    b2.wr_en   = 1'b0;
    b2.rd_en   = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    b1.wr_en = 1'b0;
    b1.rd_en = 1'b0;
    q1.delete();
    q2.delete();
    m_words = 0;
    m_slice = 0;
    chk("rst_wr_count",     32'(b1.wr_count),     32'd0);
    chk("rst_rd_count",     32'(b1.rd_count),     32'd0);
    chk("rst_empty",        32'(b1.empty),        32'd1);
    chk("rst_almost_empty", 32'(b1.almost_empty), 32'd1);
    chk("rst_full",         32'(b1.full),         32'd0);
    chk("rst_almost_full",  32'(b1.almost_full),  32'd0);
    chk("rst_overflow",     32'(b1.overflow),     32'd0);
    chk("rst_underflow",    32'(b1.underflow),    32'd0);
    chk("rst_rd_data",      32'(b1.rd_data),      32'd0);
  endtask

  task automatic cyc2(input logic we, input logic [15:0] wd, input logic re,
                      input int exp_rdc, input logic exp_ae);
    b2.wr_en   = we;
    b2.wr_data = wd;
    b2.rd_en   = re;
    @(negedge clk);
    b2.wr_en = 1'b0;
    b2.rd_en = 1'b0;
    chk("w16_rd_count",     32'(b2.rd_count),     32'(exp_rdc));
    chk("w16_almost_empty", 32'(b2.almost_empty), 32'(exp_ae));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic wa;
    rst_n      = 1'b0;
    b1.wr_en   = 1'b0;
    b1.rd_en   = 1'b0;
    b1.wr_data = '0;
    b2.wr_en   = 1'b0;
    b2.rd_en   = 1'b0;
    b2.wr_data = '0;
    @(negedge clk);
    do_reset(1'b0, 1'b0);

    // 0xB4 -> slices 2,3,1,0
    cyc(1'b1, 8'hB4, 1'b0, wa);
    q1.push_back(2'd2); q1.push_back(2'd3); q1.push_back(2'd1); q1.push_back(2'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, wa);

    // Fill to full, refused 0xFF, drain 64 slices
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, wa);
      if (wa) push_word(8'(i));
    end
    cyc(1'b1, 8'hFF, 1'b0, wa);
    if (wa) push_word(8'hFF);
    for (int i = 0; i < 64; i++) cyc(1'b0, 8'h00, 1'b1, wa);

    // Underflow after reset
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, wa);
      chk("uf_rd_data", 32'(b1.rd_data), 32'd0);
    end

    // Continuous write and read
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, 8'(i * 37 + 5), 1'b1, wa);
      if (wa) push_word(8'(i * 37 + 5));
    end
    for (int i = 0; i < 80; i++) begin
      if (m_words * 4 - m_slice != 0) cyc(1'b0, 8'h00, 1'b1, wa);
    end

    // Reset mid-operation with accesses requested during reset
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, wa);
      if (wa) push_word(8'(8'h10 + i));
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1, wa);
    do_reset(1'b1, 1'b1);
    cyc(1'b1, 8'h5A, 1'b0, wa);
    q1.push_back(2'd1); q1.push_back(2'd1); q1.push_back(2'd2); q1.push_back(2'd2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, wa);

    // 16-bit / RATIO 2 / DEPTH 8 instance
    q2.push_back(8'hA1); q2.push_back(8'hB2); q2.push_back(8'hC3); q2.push_back(8'hD4);
    cyc2(1'b1, 16'hA1B2, 1'b0, 2, 1'b1);
    cyc2(1'b1, 16'hC3D4, 1'b0, 4, 1'b0);
    cyc2(1'b0, 16'h0000, 1'b1, 3, 1'b0);
    cyc2(1'b0, 16'h0000, 1'b1, 2, 1'b1);
    cyc2(1'b0, 16'h0000, 1'b1, 1, 1'b1);
    cyc2(1'b0, 16'h0000, 1'b1, 0, 1'b1);
    chk("w16_empty", 32'(b2.empty), 32'd1);

    @(negedge clk);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
